cam_hex_tx: RTL and testbench
=============================

Name: cam_hex_tx

Overview:
- Transmit side of the CAM serial command interface.
- Accepts one CAM word (for example comparand, mask or read_lines) through a valid/ready load handshake.
- Serialises the word as uppercase ASCII hex, MSB nibble first, followed by "\r\n", onto the usb_uart input byte pipeline (uart_in_data/valid/ready).
- Replaces the ad-hoc SEND state in the top-level command FSM, so GET responses become human-readable hex.

Parameters:
- WORD_BITS, default 32: width of the word to print. Must be a multiple of 4 and at least 4; other values are an elaboration error.
- NDIGITS, default WORD_BITS/4: number of hex digits per frame. Derived; not to be overridden.

Ports:
- clk_48mhz  in  1  system clock; all logic is on its rising edge
- reset  in  1  synchronous, active-high reset
- word_in  in  WORD_BITS  word to transmit; sampled only on load handshake
- word_valid  in  1  load request
- word_ready  out  1  block idle and able to accept a word
- out_data  out  8  ASCII byte to usb_uart (uart_in_data)
- out_valid  out  1  out_data valid (uart_in_valid)
- out_ready  in  1  usb_uart accepts byte (uart_in_ready)
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse after the final byte ("\n") is accepted

Behaviour:
- Reset values (next edge with reset=1): state IDLE, out_valid=0, out_data=8'h00, busy=0, done=0, digit counter=0, shift register=0. word_ready=1 from the first cycle after reset.
- Handshakes:
  - Load occurs when word_valid && word_ready.
  - A byte transfers when out_valid && out_ready on the same edge.
  - While out_valid=1 and out_ready=0, out_data must be held stable.
  - out_valid never deasserts without a transfer, except on reset.
- State machine: IDLE -> DIGIT -> CR -> LF -> IDLE.
  - IDLE: word_ready=1, busy=0. On load, capture word_in into the shift register, set counter=NDIGITS-1, drive out_data=ascii(word_in[WORD_BITS-1 -: 4]) and out_valid=1, go to DIGIT. The first byte is valid on the cycle after the load (latency 1).
  - DIGIT: on transfer, if counter==0 load out_data=8'h0D and go to CR; otherwise shift the register left by 4, decrement counter, and load the next nibble's ascii.
  - CR: on transfer, load out_data=8'h0A and go to LF.
  - LF: on transfer, out_valid=0, done=1 for exactly one cycle, go to IDLE. word_ready=1 on the same cycle as done.
- Nibble encoding: 0-9 -> 8'h30+n; 10-15 -> 8'h37+n (uppercase A-F). Leading zeros are always printed; the frame is always NDIGITS+2 bytes.
- Throughput: with out_ready held at 1, one byte per cycle; a frame occupies NDIGITS+2 consecutive cycles. Back-to-back frames have a one-cycle gap (the IDLE cycle in which the load occurs).
- Boundaries:
  - word_valid while busy: ignored (word_ready=0); there is no queueing.
  - word_in changes after load: no effect on the frame in progress.
  - out_ready stuck at 0: the block waits indefinitely; there is no timeout.
  - reset mid-frame: the frame is abandoned, out_valid=0 on the next cycle, no done pulse, block returns to IDLE.
  - out_ready asserted with out_valid=0: no effect.
- busy = (state != IDLE); it is registered with the state.

Decomposition:
- Shared package cam_serial_pkg contains:
  - ASCII constants CHAR_CR=8'h0D, CHAR_LF=8'h0A, CHAR_0=8'h30.
  - the state enum type tx_state_t {IDLE, DIGIT, CR, LF}.
  - function nibble_to_ascii(4-bit) -> 8-bit. The future receive-side hex parser will reuse this package.
- No sub-module: the datapath is a shift register plus a counter, and the FSM is kept in one module.

Test Plan:
- 0x1234ABCD, out_ready=1, load at cycle N -> out_valid during N+1..N+10 with bytes 31 32 33 34 41 42 43 44 0D 0A; done high only at N+11; word_ready high at N+11.
- 0x1234ABCD with out_ready toggling 1,0,0,1,... -> same 10-byte sequence; out_data constant on every stalled cycle; no byte duplicated or skipped.
- 0x00000000 then 0xFFFFFFFF loaded back-to-back -> "00000000\r\n" then "FFFFFFFF\r\n"; exactly one idle cycle between frames.
- word_valid held high with a changing word_in during a frame -> only the originally captured word is printed; the second word loads only after done.
- reset asserted after 3 bytes are accepted -> out_valid=0 and busy=0 on the next cycle, no done pulse; the next load of 0x000000A5 yields "000000A5\r\n".
- WORD_BITS=8, word 0x5A -> bytes 35 41 0D 0A; done one cycle after the 0A handshake.

Source files
------------

// File: rtl/cam_serial_pkg.sv
// Shared definitions for the CAM serial command interface (transmit and receive sides).
package cam_serial_pkg;

  localparam logic [7:0] CHAR_CR = 8'h0D;
  localparam logic [7:0] CHAR_LF = 8'h0A;
  localparam logic [7:0] CHAR_0  = 8'h30;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DIGIT = 2'd1,
    CR    = 2'd2,
    LF    = 2'd3
  } tx_state_t;

  // Uppercase hex: 0-9 -> '0'..'9', 10-15 -> 'A'..'F'.
  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
    logic [7:0] wide;
    wide = {4'h0, nib};
    if (nib < 4'd10) begin
      return CHAR_0 + wide;
    end
    return 8'h37 + wide;
  endfunction

endpackage

// File: rtl/cam_hex_tx_if.sv
// Load handshake, byte pipeline to usb_uart, and status/debug signals of cam_hex_tx.
interface cam_hex_tx_if
  import cam_serial_pkg::*;
#(
  parameter int WORD_BITS = 32
);

  // Both channels are valid/ready: a transfer happens on an edge where valid and ready
  // are both high; a raised valid is held, with its data stable, until that transfer.
  logic [WORD_BITS-1:0] word_in;
  logic                 word_valid;
  logic                 word_ready;
  logic [7:0]           out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic                 busy;
  logic                 done;
  tx_state_t            state;

  modport master (
    output word_in,
    output word_valid,
    output out_ready,
    input  word_ready,
    input  out_data,
    input  out_valid,
    input  busy,
    input  done,
    input  state
  );

  modport slave (
    input  word_in,
    input  word_valid,
    input  out_ready,
    output word_ready,
    output out_data,
    output out_valid,
    output busy,
    output done,
    output state
  );

endinterface

// File: rtl/cam_hex_tx.sv
// Prints one CAM word as uppercase ASCII hex (MSB nibble first) followed by "\r\n"
// onto the usb_uart input byte pipeline.
module cam_hex_tx
  import cam_serial_pkg::*;
#(
  parameter int WORD_BITS = 32
) (
  input  logic           clk_48mhz,
  input  logic           reset,
  cam_hex_tx_if.slave    bus
);

  localparam int NDIGITS = WORD_BITS / 4;
  localparam int CW      = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

  if (((WORD_BITS % 4) != 0) || (WORD_BITS < 4)) begin : g_bad_width
    $error("cam_hex_tx: WORD_BITS must be a multiple of 4 and at least 4");
  end

  tx_state_t            state;
  tx_state_t            state_n;
  logic [WORD_BITS-1:0] shreg;
  logic [WORD_BITS-1:0] shreg_n;
  logic [WORD_BITS-1:0] shifted;
  logic [CW-1:0]        cnt;
  logic [CW-1:0]        cnt_n;
  logic [7:0]           data_q;
  logic [7:0]           data_n;
  logic                 valid_q;
  logic                 valid_n;
  logic                 busy_q;
  logic                 busy_n;
  logic                 done_q;
  logic                 done_n;
  logic                 xfer;

  assign xfer    = valid_q && bus.out_ready;
  assign shifted = shreg << 4;

  always_comb begin
    state_n = state;
    shreg_n = shreg;
    cnt_n   = cnt;
    data_n  = data_q;
    valid_n = valid_q;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.word_valid) begin
          shreg_n = bus.word_in;
          cnt_n   = CW'(NDIGITS - 1);
          data_n  = nibble_to_ascii(bus.word_in[WORD_BITS-1 -: 4]);
          valid_n = 1'b1;
          state_n = DIGIT;
        end
      end
      DIGIT: begin
        if (xfer) begin
          if (cnt == '0) begin
            data_n  = CHAR_CR;
            state_n = CR;
          end else begin
            // The current digit always sits in the top nibble of the register.
            shreg_n = shifted;
            cnt_n   = cnt - CW'(1);
            data_n  = nibble_to_ascii(shifted[WORD_BITS-1 -: 4]);
          end
        end
      end
      CR: begin
        if (xfer) begin
          data_n  = CHAR_LF;
          state_n = LF;
        end
      end
      LF: begin
        if (xfer) begin
          valid_n = 1'b0;
          done_n  = 1'b1;
          state_n = IDLE;
        end
      end
      default: begin
        valid_n = 1'b0;
        state_n = IDLE;
      end
    endcase
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk_48mhz) begin
    if (reset) begin
      state   <= IDLE;
      shreg   <= '0;
      cnt     <= '0;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_n;
      shreg   <= shreg_n;
      cnt     <= cnt_n;
      data_q  <= data_n;
      valid_q <= valid_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
    end
  end

  // word_ready rises on the same cycle as done because both follow the LF transfer.
  assign bus.word_ready = (state == IDLE);
  assign bus.out_data   = data_q;
  assign bus.out_valid  = valid_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.state      = state;

endmodule

// File: tb/tb_cam_hex_tx.sv
// Self-checking bench for cam_hex_tx: 32-bit and 8-bit instances with byte scoreboards.
module tb_cam_hex_tx;
  import cam_serial_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   xfer_cnt = 0;
  int   load_cyc = 0;
  int   mode = 3;
  int   mode8 = 1;
  int   ph = 0;

  logic [7:0] exp_q[$];
  logic [7:0] exp8_q[$];

  cam_hex_tx_if #(.WORD_BITS(32)) bus ();
  cam_hex_tx_if #(.WORD_BITS(8))  bus8 ();

  cam_hex_tx #(.WORD_BITS(32)) dut (.clk_48mhz(clk), .reset(rst), .bus(bus));
  cam_hex_tx #(.WORD_BITS(8))  dut8 (.clk_48mhz(clk), .reset(rst), .bus(bus8));

  // clock / reset / cycle counter
  always #10 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    if (n > 4'd9) return 8'h41 + 8'(n - 4'd10);
    return 8'h30 + 8'(n);
  endfunction

  task automatic push32(input logic [31:0] w);
    for (int i = 7; i >= 0; i--) exp_q.push_back(hex_char(w[i*4 +: 4]));
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  // out_ready drivers: 0 = always, 1 = pattern 1,0,0, 2 = random, 3 = stuck low
  always @(posedge clk) begin
    #2;
    case (mode)
      0: bus.out_ready = 1'b1;
      1: begin bus.out_ready = (ph % 3 == 0); ph++; end
      2: bus.out_ready = 1'($urandom_range(0, 1));
      default: bus.out_ready = 1'b0;
    endcase
    bus8.out_ready = (mode8 == 1) ? 1'b1 : 1'($urandom_range(0, 1));
  end

  // scoreboard monitor, 32-bit instance
  bit stall_q = 0;
  bit lf_q = 0;
  always @(negedge clk) begin
    if (rst) begin
      stall_q = 0;
      lf_q = 0;
    end else begin
      check("done", bus.done, lf_q);
      lf_q = 0;
      if (stall_q) check("valid_hold", bus.out_valid, 1);
      if (bus.out_valid) begin
        check("byte_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          check("data", bus.out_data, exp_q[0]);
          if (bus.out_ready) begin
            lf_q = (exp_q[0] == 8'h0A);
            void'(exp_q.pop_front());
            xfer_cnt++;
          end
        end
      end
      stall_q = bus.out_valid && !bus.out_ready;
    end
  end

  // scoreboard monitor, 8-bit instance
  bit stall8_q = 0;
  bit lf8_q = 0;
  always @(negedge clk) begin
    if (rst) begin
      stall8_q = 0;
      lf8_q = 0;
    end else begin
      check("done8", bus8.done, lf8_q);
      lf8_q = 0;
      if (stall8_q) check("valid_hold8", bus8.out_valid, 1);
      if (bus8.out_valid) begin
        check("byte_expected8", exp8_q.size() != 0, 1);
        if (exp8_q.size() != 0) begin
          check("data8", bus8.out_data, exp8_q[0]);
          if (bus8.out_ready) begin
            lf8_q = (exp8_q[0] == 8'h0A);
            void'(exp8_q.pop_front());
          end
        end
      end
      stall8_q = bus8.out_valid && !bus8.out_ready;
    end
  end

  // driver tasks
  task automatic load32(input logic [31:0] w, input bit scramble);
    int n = 0;
    bus.word_in = w;
    bus.word_valid = 1'b1;
    while (!bus.word_ready && n < 300) begin
      if (scramble) bus.word_in = $urandom;
      @(posedge clk); #1;
      n++;
    end
    check("load_wait", n < 300, 1);
    bus.word_in = w;
    @(posedge clk);
    push32(w);
    #1;
    load_cyc = cyc;
    bus.word_valid = 1'b0;
    bus.word_in = $urandom;
    @(negedge clk);
    check("first_valid", bus.out_valid, 1);
    check("first_busy", bus.busy, 1);
    check("ready_low", bus.word_ready, 0);
  endtask

  task automatic load8(input logic [7:0] w);
    int n = 0;
    bus8.word_in = w;
    bus8.word_valid = 1'b1;
    while (!bus8.word_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("load8_wait", n < 100, 1);
    @(posedge clk);
    exp8_q.push_back(hex_char(w[7:4]));
    exp8_q.push_back(hex_char(w[3:0]));
    exp8_q.push_back(8'h0D);
    exp8_q.push_back(8'h0A);
    #1;
    bus8.word_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || exp8_q.size() != 0 || !bus.word_ready || !bus8.word_ready)
           && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    check("idle_wait", n < 500, 1);
  endtask

  initial begin
    int prev;
    int base;
    int n;
    bus.word_in = '0;
    bus.word_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus8.word_in = '0;
    bus8.word_valid = 1'b0;
    bus8.out_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_valid", bus.out_valid, 0);
    check("rst_data", bus.out_data, 8'h00);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_state", bus.state, IDLE);
    check("rst_ready", bus.word_ready, 1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    mode = 0;
    @(posedge clk); #1;

    // full-rate frame
    load32(32'h1234ABCD, 0);
    wait_idle();

    // stalled frame, ready pattern 1,0,0
    mode = 1;
    load32(32'h1234ABCD, 0);
    wait_idle();

    // back-to-back frames: one idle cycle between them
    mode = 0;
    load32(32'h00000000, 0);
    prev = load_cyc;
    load32(32'hFFFFFFFF, 0);
    check("b2b_gap", load_cyc - prev, 11);
    wait_idle();

    // word_valid kept up with a changing word during the frame
    load32(32'hDEADBEEF, 0);
    bus.word_valid = 1'b1;
    prev = load_cyc;
    load32(32'h0BADF00D, 1);
    check("hold_gap", load_cyc - prev, 11);
    wait_idle();

    // reset after three accepted bytes
    base = xfer_cnt;
    load32(32'h1234ABCD, 0);
    n = 0;
    while (xfer_cnt < base + 3 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("rst_mid_wait", n < 100, 1);
    rst = 1'b1;
    mode = 3;
    exp_q.delete();
    @(posedge clk); #1;
    check("rstmid_valid", bus.out_valid, 0);
    check("rstmid_busy", bus.busy, 0);
    check("rstmid_done", bus.done, 0);
    rst = 1'b0;
    mode = 0;
    @(posedge clk); #1;
    check("rstmid_nodone", bus.done, 0);
    check("rstmid_state", bus.state, IDLE);
    load32(32'h000000A5, 0);
    wait_idle();

    // random words under random backpressure
    mode = 2;
    for (int i = 0; i < 6; i++) load32($urandom, 0);
    wait_idle();
    mode = 0;

    // 8-bit instance
    load8(8'h5A);
    wait_idle();
    mode8 = 0;
    for (int i = 0; i < 5; i++) load8(8'($urandom_range(0, 255)));
    wait_idle();

    check("q_empty", exp_q.size(), 0);
    check("q8_empty", exp8_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
